// File: rtl/analyzer_capture_sequencer.sv
// analyzer_capture_sequencer
//
// Sequences one trace capture into the circular sample buffer. The steps are:
//   arm -> pre-trigger fill -> wait for trigger -> post-trigger fill -> idle
// When a capture completes normally, the capture window is published on
// sampleNumber_Begin/sampleNumber_End and idle is raised for the readback FSM.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low reset
//   arm                 one-cycle start pulse, honoured only while idle
//   abort               one-cycle cancel pulse, honoured while busy
//   trigger             trigger-unit hit (level), sampled each clock
//   pre_count           pre-trigger sample count, latched at arm
//   post_count          post-trigger sample count (incl. trigger sample),
//                       latched at arm; 0 behaves as 1
//   sample_valid        a new sample is available this cycle
//   write_allowed       trace memory accepts a write this cycle
//   write_req           write request to trace memory (combinational)
//   writeSampleNumber   write address, zero-extended write pointer
//   idle                registered, high while the sequencer is idle
//   triggered           set when the trigger is captured, cleared at arm
//   overflow            sticky dropped-sample flag, cleared at arm
//   capture_done        one-cycle pulse on normal completion
//   sampleNumber_Begin  first sample of the captured window
//   sampleNumber_End    last sample of the captured window
//   dbg_state           current sequencer state, for observation only
//
// Write handshake: write_req is a valid and write_allowed is a ready. A sample
// is written only in a cycle where both are high. When write_req is high and
// write_allowed is low, the sample is dropped. It is not held for a later cycle.

module analyzer_capture_sequencer #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              sample_valid,
    input  logic              write_allowed,
    output logic              write_req,
    output logic [31:0]       writeSampleNumber,
    output logic              idle,
    output logic              triggered,
    output logic              overflow,
    output logic              capture_done,
    output logic [31:0]       sampleNumber_Begin,
    output logic [31:0]       sampleNumber_End,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_FILL  = 2'd1,
        ST_WAIT_TRIG = 2'd2,
        ST_POST_FILL = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] post_lat;
    logic [ADDR_W-1:0] begin_r;
    logic [ADDR_W-1:0] end_r;

    logic              accept;
    logic              drop;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] post_eff;

    assign write_req = sample_valid && (state != ST_IDLE);
    assign accept    = write_req && write_allowed;
    assign drop      = write_req && !write_allowed;
    assign cnt_inc   = cnt + ADDR_W'(1);
    // A post count of zero still captures the trigger sample itself.
    assign post_eff  = (post_lat == '0) ? ADDR_W'(1) : post_lat;

    assign writeSampleNumber  = 32'(wr_ptr);
    assign sampleNumber_Begin = 32'(begin_r);
    assign sampleNumber_End   = 32'(end_r);
    assign dbg_state          = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            trig_ptr     <= '0;
            cnt          <= '0;
            pre_lat      <= '0;
            post_lat     <= '0;
            begin_r      <= '0;
            end_r        <= '0;
            idle         <= 1'b1;
            triggered    <= 1'b0;
            overflow     <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= 1'b0;

            // Pointer and overflow tracking follow the write handshake in
            // every busy state, including a cycle in which abort is seen.
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        pre_lat   <= pre_count;
                        post_lat  <= post_count;
                        cnt       <= '0;
                        triggered <= 1'b0;
                        overflow  <= 1'b0;
                        idle      <= 1'b0;
                        state     <= (pre_count == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                    end
                end

                ST_PRE_FILL: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end else if (accept) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == pre_lat) begin
                            state <= ST_WAIT_TRIG;
                        end
                    end
                end

                ST_WAIT_TRIG: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end else if (trigger) begin
                        trig_ptr  <= wr_ptr;
                        triggered <= 1'b1;
                        // A write accepted in the trigger cycle is post sample 1.
                        // If that alone fills the window, the capture finishes here.
                        if (accept && (post_eff == ADDR_W'(1))) begin
                            state        <= ST_IDLE;
                            idle         <= 1'b1;
                            capture_done <= 1'b1;
                            begin_r      <= wr_ptr - pre_lat;
                            end_r        <= wr_ptr;
                        end else begin
                            cnt   <= accept ? ADDR_W'(1) : '0;
                            state <= ST_POST_FILL;
                        end
                    end
                end

                ST_POST_FILL: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end else if (accept) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == post_eff) begin
                            state        <= ST_IDLE;
                            idle         <= 1'b1;
                            capture_done <= 1'b1;
                            begin_r      <= trig_ptr - pre_lat;
                            end_r        <= trig_ptr + post_eff - ADDR_W'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_analyzer_capture_sequencer.sv
module tb_analyzer_capture_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          arm, abort, trigger, sample_valid, write_allowed;
    logic [AW-1:0] pre_count, post_count;
    logic          write_req, idle, triggered, overflow, capture_done;
    logic [31:0]   writeSampleNumber, sampleNumber_Begin, sampleNumber_End;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    analyzer_capture_sequencer #(.ADDR_W(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .arm                (arm),
        .abort              (abort),
        .trigger            (trigger),
        .pre_count          (pre_count),
        .post_count         (post_count),
        .sample_valid       (sample_valid),
        .write_allowed      (write_allowed),
        .write_req          (write_req),
        .writeSampleNumber  (writeSampleNumber),
        .idle               (idle),
        .triggered          (triggered),
        .overflow           (overflow),
        .capture_done       (capture_done),
        .sampleNumber_Begin (sampleNumber_Begin),
        .sampleNumber_End   (sampleNumber_End),
        .dbg_state          (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];   // expected {Begin[15:0], End[15:0]} per completion

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Capture described as "samples still owed": pre samples left before the
    // trigger is looked for, then post samples counted from the trigger sample.
    bit m_busy, m_in_post, m_trig, m_ovf, m_done;
    int m_ptr, m_pre, m_need, m_pre_left, m_got, m_tp, m_begin, m_end;

    task automatic model_reset();
        m_busy = 0; m_in_post = 0; m_trig = 0; m_ovf = 0; m_done = 0;
        m_ptr = 0; m_begin = 0; m_end = 0; m_tp = 0;
        exp_q.delete();
    endtask

    task automatic model_finish();
        m_busy  = 0;
        m_done  = 1;
        m_begin = (((m_tp - m_pre) % DEPTH) + DEPTH) % DEPTH;
        m_end   = (m_tp + m_need - 1) % DEPTH;
        exp_q.push_back((m_begin << 16) | m_end);
    endtask

    task automatic model_step(input bit a, input bit ab, input bit tr, input bit sv, input bit wa);
        bit acc, drp;
        acc    = m_busy && sv && wa;
        drp    = m_busy && sv && !wa;
        m_done = 0;
        if (!m_busy) begin
            if (a) begin
                m_busy     = 1;
                m_pre      = int'(pre_count);
                m_need     = (post_count == 0) ? 1 : int'(post_count);
                m_pre_left = m_pre;
                m_in_post  = 0;
                m_got      = 0;
                m_trig     = 0;
                m_ovf      = 0;
            end
        end else begin
            if (drp) m_ovf = 1;
            if (ab) begin
                m_busy = 0;
            end else if (m_in_post) begin
                if (acc) begin
                    m_got++;
                    if (m_got == m_need) model_finish();
                end
            end else if (m_pre_left > 0) begin
                if (acc) m_pre_left--;
            end else if (tr) begin
                m_trig    = 1;
                m_tp      = m_ptr;
                m_in_post = 1;
                m_got     = acc ? 1 : 0;
                if (m_got == m_need) model_finish();
            end
        end
        if (acc) m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    function automatic bit m_waiting();
        return m_busy && !m_in_post && (m_pre_left == 0);
    endfunction

    task automatic check_regs();
        check("idle",         idle,               !m_busy);
        check("triggered",    triggered,          m_trig);
        check("overflow",     overflow,           m_ovf);
        check("capture_done", capture_done,       m_done);
        check("begin",        sampleNumber_Begin, m_begin);
        check("end",          sampleNumber_End,   m_end);
    endtask

    // ---------------- driver ----------------
    // Inputs are driven after the falling edge and checked before the rising
    // edge. Registered outputs are checked 1 time unit after the rising edge.
    task automatic cycle(input bit a, input bit ab, input bit tr, input bit sv, input bit wa);
        arm = a; abort = ab; trigger = tr; sample_valid = sv; write_allowed = wa;
        #1;
        check("write_req", write_req,         m_busy && sv);
        check("wr_addr",   writeSampleNumber, m_ptr);
        @(posedge clk);
        model_step(a, ab, tr, sv, wa);
        #1;
        check_regs();
        if (capture_done && exp_q.size() > 0)
            check("window", {sampleNumber_Begin[15:0], sampleNumber_End[15:0]}, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic start(input int pre, input int post);
        pre_count  = AW'(pre);
        post_count = AW'(post);
        cycle(1, 0, 0, 1, 1);
    endtask

    // Drive writes until the model is waiting for the trigger at pointer tgt.
    task automatic run_to_ptr(input int tgt);
        for (int n = 0; n < 64 && !(m_waiting() && m_ptr == tgt); n++) cycle(0, 0, 0, 1, 1);
        check("reach_ptr", writeSampleNumber, tgt);
    endtask

    task automatic run_to_wait();
        for (int n = 0; n < 64 && !m_waiting(); n++) cycle(0, 0, 0, 1, 1);
        check("reach_wait", dbg_state, 2);
    endtask

    task automatic run_to_idle(input bit random_wa);
        for (int n = 0; n < 128 && m_busy; n++)
            cycle(0, 0, 0, 1, random_wa ? bit'($urandom_range(0, 1)) : 1'b1);
        check("reach_idle", idle, 1);
    endtask

    task automatic mid_reset();
        sample_valid = 1;
        reset = 0;
        #2;
        model_reset();
        check("rst_write_req", write_req, 0);
        check("rst_wr_addr",   writeSampleNumber, 0);
        check_regs();
        @(negedge clk);
        reset = 1;
    endtask

    // ---------------- test sequence ----------------
    int tp_saved;

    initial begin
        reset = 0; arm = 0; abort = 0; trigger = 0; sample_valid = 0; write_allowed = 0;
        pre_count = '0; post_count = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_wr_addr", writeSampleNumber, 0);
        check_regs();
        reset = 1;
        @(negedge clk);

        // First capture, without pointer wrap.
        start(3, 5);
        run_to_ptr(10);
        cycle(0, 0, 1, 1, 1);
        run_to_idle(0);
        check("t1_begin", sampleNumber_Begin, 7);
        check("t1_end",   sampleNumber_End, 14);

        // Second capture, continuing circularly through the pointer wrap.
        check("t2_start_ptr", writeSampleNumber, 15);
        start(3, 5);
        run_to_ptr(14);
        cycle(0, 0, 1, 1, 1);
        run_to_idle(0);
        check("t2_begin", sampleNumber_Begin, 11);
        check("t2_end",   sampleNumber_End, 2);

        // Dropped samples during the post-trigger fill.
        start(2, 5);
        run_to_wait();
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 0);
        run_to_idle(1);
        check("t3_overflow", overflow, 1);
        start(1, 2);
        check("t3_ovf_cleared", overflow, 0);
        cycle(0, 1, 0, 1, 1);

        // Zero pre/post counts: the window is the trigger sample alone.
        start(0, 0);
        check("t4_direct_wait", dbg_state, 2);
        tp_saved = m_ptr;
        cycle(0, 0, 1, 1, 1);
        check("t4_begin", sampleNumber_Begin, tp_saved);
        check("t4_end",   sampleNumber_End, tp_saved);

        // Abort cases and an arm pulse ignored during the post-trigger fill.
        start(1, 3);
        run_to_wait();
        cycle(0, 1, 0, 1, 1);
        check("t5_abort_begin", sampleNumber_Begin, tp_saved);
        start(1, 3);
        run_to_wait();
        cycle(0, 1, 1, 1, 1);
        check("t5_abort_trig", triggered, 0);
        start(2, 4);
        run_to_wait();
        cycle(0, 0, 1, 1, 1);
        cycle(1, 0, 0, 1, 1);
        run_to_idle(0);

        // Trigger ignored during the pre-trigger fill; reset mid post fill.
        start(4, 6);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 0, 1);
        run_to_wait();
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1);
        mid_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit a;
            a = ($urandom_range(0, 7) == 0);
            if (a) begin
                pre_count  = AW'($urandom_range(0, 6));
                post_count = AW'($urandom_range(0, 8));
            end
            cycle(a, $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end

        check("window_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/analyzer_capture_sequencer.md
Name: analyzer_capture_sequencer

Overview:
- Sequences one trace capture into the circular sample buffer: arm, pre-trigger fill, wait for trigger, post-trigger fill, then return to idle.
- Drives buffer write requests and addresses, and sits between the trigger unit / sampler front end and trace memory.
- On completion it publishes the sampleNumber_Begin/sampleNumber_End window and the idle status consumed by the readback FSM.

Parameters:
- ADDR_W, 25: buffer address width; depth is 2^ADDR_W samples, and all pointer arithmetic is mod 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- arm  in  1  one-cycle start-capture pulse; honoured only in IDLE
- abort  in  1  one-cycle pulse; cancels the capture in progress
- trigger  in  1  trigger-unit hit, level, sampled each clk
- pre_count  in  ADDR_W  pre-trigger samples; latched at arm
- post_count  in  ADDR_W  post-trigger samples incl. the trigger sample; latched at arm; 0 is treated as 1
- sample_valid  in  1  new sample available this cycle
- write_allowed  in  1  memory accepts a write this cycle
- write_req  out  1  write request
- writeSampleNumber  out  32  write address, zero-extended wr_ptr
- idle  out  1  sequencer in IDLE
- triggered  out  1  set on trigger capture, cleared on arm
- overflow  out  1  sticky; set when a sample is dropped, cleared on arm
- capture_done  out  1  one-cycle pulse on normal completion
- sampleNumber_Begin  out  32  first sample of the window, zero-extended
- sampleNumber_End  out  32  last sample of the window, zero-extended

Behaviour:
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL.
- Reset values: state=IDLE, wr_ptr=0, idle=1, write_req=0, triggered=0, overflow=0, capture_done=0, Begin=0, End=0.
- Reset mid-capture behaves the same way: immediate return to IDLE, wr_ptr=0.
- idle is registered and equals (state==IDLE).
- write_req = sample_valid && state!=IDLE. It is combinational.
- A write is accepted when write_req && write_allowed in the same cycle.
- On each accepted write, wr_ptr increments mod 2^ADDR_W; writeSampleNumber shows the pre-increment value.
- Dropped sample: write_req && !write_allowed. Set overflow. Do not advance wr_ptr or any counter.
- wr_ptr is not cleared by arm; captures continue circularly from the previous pointer.
- IDLE:
  - On arm: latch pre_count/post_count, clear cnt, triggered and overflow.
  - Next state is PRE_FILL, or WAIT_TRIG if pre_count==0.
- PRE_FILL:
  - cnt counts accepted writes; trigger is ignored.
  - When the accepted write makes cnt==pre_count, go to WAIT_TRIG.
- WAIT_TRIG:
  - Accepted writes continue circularly.
  - On trigger==1: trig_ptr<=wr_ptr (pre-increment value), triggered<=1, cnt<=0, go to POST_FILL.
  - A write accepted in the trigger cycle is the trigger sample and counts as post sample 1.
- POST_FILL:
  - cnt counts accepted writes. When the accepted write makes cnt==post_count (0 treated as 1), go to IDLE.
  - On that transition: pulse capture_done, Begin<=(trig_ptr-pre_count) mod 2^ADDR_W, End<=(trig_ptr+post_count-1) mod 2^ADDR_W.
  - Begin and End are stable and valid from the first cycle idle==1.
- abort in any non-IDLE state: IDLE next cycle, no capture_done, Begin/End unchanged, triggered retains its value.
- abort has priority over trigger and over completion in the same cycle.
- arm outside IDLE is ignored. arm and abort together in IDLE: arm wins.
- Configuration rule: pre_count+post_count <= 2^ADDR_W-1. Outside this rule the window contents are undefined, but the state machine still terminates.
- All state-changing logic is on posedge clk; reset is asynchronous (negedge reset).

Test Plan:
- ADDR_W=4, reset, wr_ptr=0, arm with pre=3/post=5, sample_valid=1, write_allowed=1, trigger at wr_ptr=10 -> addresses 0..14 written, trig_ptr=10, Begin=7, End=14, capture_done one pulse, idle=1.
- Continue from wr_ptr=15, pre=3/post=5, trigger when wr_ptr=14 after wrap -> Begin=11, End=2; writeSampleNumber wraps 15->0.
- Random write_allowed deasserts while sample_valid=1 during POST_FILL -> overflow=1, wr_ptr holds on drops, exactly 5 accepted post writes before IDLE; arm clears overflow.
- pre=0/post=0 -> IDLE->WAIT_TRIG directly; trigger with same-cycle accepted write -> single sample captured, Begin=End=trig_ptr, idle next cycle.
- abort in WAIT_TRIG, and abort coincident with trigger -> IDLE next cycle, no capture_done, Begin/End hold previous values; arm pulsed in POST_FILL -> ignored.
- reset low mid-POST_FILL -> all outputs return to reset values immediately; trigger high in PRE_FILL -> ignored.
